hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised per-register interlock unit for the in-order R/I/J pipeline. It supersedes the single global register/memory countdown with one countdown counter per architectural register. The unit stalls the ID stage only on true RAW dependences, and the stall length depends on whether forwarding is enabled. It also inserts a configurable number of control bubbles after each issued branch, and sits between the ID decoder and the IF/ID pipeline-register enables.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked
REG_AW, 5, register address width (2^REG_AW >= NREGS)
FWD_EN, 1, 1 = EX/MEM forwarding present; 0 = readers wait for register-file writeback
WB_STALL, 3, stall cycles for a RAW hazard when FWD_EN=0 (any producer)
LOAD_STALL, 1, stall cycles for load-use when FWD_EN=1
BR_BUBBLES, 2, control bubbles inserted after a branch issues (0 disables)

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_rs  in  REG_AW  source register 1
id_rt  in  REG_AW  source register 2
id_use_rs  in  1  instruction reads id_rs
id_use_rt  in  1  instruction reads id_rt
id_wr_en  in  1  instruction writes a register
id_wr_addr  in  REG_AW  destination register
id_is_load  in  1  instruction is a load (its result comes from memory)
id_is_branch  in  1  instruction is a branch or jump
flush  in  1  synchronous squash of all in-flight instructions
stall  out  1  hold PC and IF/ID; inject bubble into ID/EX
stall_data  out  1  stall cause: RAW hazard
stall_ctrl  out  1  stall cause: branch shadow
issue  out  1  id_valid & ~stall
pending  out  NREGS  bit r = 1 while cnt[r] != 0; bit 0 always 0

Behaviour:
- Storage: cnt[r] for r = 1..NREGS-1, width CNT_W = clog2(max(WB_STALL, LOAD_STALL)+1); shadow counter sh, width clog2(BR_BUBBLES+1).
- Reset (async, rst_n=0): all cnt and sh cleared to 0. All outputs are combinational from state, so stall=stall_data=stall_ctrl=issue=0 and pending=0 during reset.
- stall_ctrl = (sh != 0).
- stall_data = id_valid & ((id_use_rs & id_rs!=0 & cnt[id_rs]!=0) | (id_use_rt & id_rt!=0 & cnt[id_rt]!=0)).
- stall = stall_data | stall_ctrl. The unit itself adds zero latency; the hazard check uses current-cycle counter values.
- Each posedge, in priority order:
  1. flush=1: all cnt and sh cleared to 0. Takes priority over issue in the same cycle.
  2. Otherwise, every non-zero cnt and sh decrements by 1, whether or not the unit is stalling.
  3. If issue & id_wr_en & id_wr_addr!=0, the load value overrides the decrement: cnt[id_wr_addr] <= FWD_EN ? (id_is_load ? LOAD_STALL : 0) : WB_STALL.
  4. If issue & id_is_branch, sh <= BR_BUBBLES.
- WAW: a newer writer overwrites the counter outright, with no max. Example: a load to r5 followed by a forwardable ALU write to r5 leaves cnt[r5]=0.
- Self-dependence: an instruction reading and writing the same register is checked against the pre-issue counter value.
- An instruction with both id_wr_en and id_is_branch (e.g. jal) performs both updates.
- Out-of-range addresses (>= NREGS) are never stalled on and never tracked.
- Stall length: a reader issued k cycles after its producer stalls max(0, S-k+1) cycles, where S is the loaded value.

Test Plan:
- FWD_EN=0: add r3 issues, then `sub r4,r3,r1` is presented the next cycle -> stall_data=1 for exactly 3 cycles, then issue=1; pending[3] falls as issue rises.
- FWD_EN=1: same sequence -> no stall. `lw r3`, then a reader of r3 the next cycle -> exactly 1 stall cycle. Reader two cycles after the load -> 0 stall cycles.
- Branch with BR_BUBBLES=2 -> stall_ctrl=1 for the 2 cycles after issue, independent of id_valid. A branch that also writes r31 -> pending[31] follows the FWD_EN rule.
- Writes and reads of r0, including a load to r0, -> pending[0]=0 and never a stall.
- flush asserted on the first of 3 WB stall cycles -> next cycle pending=0, stall=0, sh=0. Flush and branch issue in the same cycle -> sh=0.
- rst_n pulled low mid-stall, asynchronously between edges -> stall and pending drop immediately. WAW: `lw r5`, then `add r5`, then a reader of r5 (FWD_EN=1) -> no stall.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage interlock bus between the decoder/pipeline control and the
// per-register hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned REG_AW = 5
);

    // Decoded instruction currently held in ID
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_addr;
    logic              id_is_load;
    logic              id_is_branch;
    logic              flush;

    // Interlock decisions back to the pipeline-register enables
    logic              stall;
    logic              stall_data;
    logic              stall_ctrl;
    logic              issue;
    logic [NREGS-1:0]  pending;

    // Decoder / pipeline-control side
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_addr, id_is_load, id_is_branch, flush,
        input  stall, stall_data, stall_ctrl, issue, pending
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_addr, id_is_load, id_is_branch, flush,
        output stall, stall_data, stall_ctrl, issue, pending
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register RAW interlock with branch-shadow bubbles. One countdown per
// architectural register replaces the old global countdown; the ID stage is
// held only while a source register still has cycles outstanding.
module hazard_scoreboard #(
    parameter int unsigned NREGS      = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned WB_STALL   = 3,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned BR_BUBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   bus
);

    localparam int unsigned MAX_STALL = (WB_STALL > LOAD_STALL) ? WB_STALL : LOAD_STALL;
    localparam int unsigned CNT_W     = (MAX_STALL == 0) ? 1 : $clog2(MAX_STALL + 1);
    localparam int unsigned SH_W      = (BR_BUBBLES == 0) ? 1 : $clog2(BR_BUBBLES + 1);

    // Counter load values: without forwarding every producer waits for writeback
    localparam logic [CNT_W-1:0] LOAD_VAL = (FWD_EN != 0) ? CNT_W'(LOAD_STALL) : CNT_W'(WB_STALL);
    localparam logic [CNT_W-1:0] ALU_VAL  = (FWD_EN != 0) ? CNT_W'(0)          : CNT_W'(WB_STALL);
    localparam logic [SH_W-1:0]  SH_VAL   = SH_W'(BR_BUBBLES);

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [SH_W-1:0]  sh_q;
    logic [SH_W-1:0]  sh_d;

    logic [NREGS-1:0] pend;
    logic             rs_busy;
    logic             rt_busy;
    logic             stall_data_c;
    logic             stall_ctrl_c;
    logic             stall_c;
    logic             issue_c;
    logic             wr_hit_c;

    // Busy lookup; r0 and addresses >= NREGS never match
    always_comb begin
        pend    = '0;
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            pend[r] = (cnt_q[r] != '0);
            if (bus.id_rs == REG_AW'(r) && pend[r]) begin
                rs_busy = 1'b1;
            end
            if (bus.id_rt == REG_AW'(r) && pend[r]) begin
                rt_busy = 1'b1;
            end
        end
    end

    // Stall decision from current counter state (zero added latency)
    always_comb begin
        stall_data_c = bus.id_valid & ((bus.id_use_rs & rs_busy) | (bus.id_use_rt & rt_busy));
        stall_ctrl_c = (sh_q != '0);
        stall_c      = stall_data_c | stall_ctrl_c;
        issue_c      = bus.id_valid & ~stall_c & rst_n;
        wr_hit_c     = issue_c & bus.id_wr_en;
    end

    assign bus.stall      = stall_c;
    assign bus.stall_data = stall_data_c;
    assign bus.stall_ctrl = stall_ctrl_c;
    assign bus.issue      = issue_c;
    assign bus.pending    = pend;

    // Next counter state: flush > issue load > free-running decrement
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = '0;
        end
        sh_d = '0;
        if (!bus.flush) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
                // Newest writer wins outright, so WAW never extends a stall
                if (wr_hit_c && bus.id_wr_addr == REG_AW'(r)) begin
                    cnt_d[r] = bus.id_is_load ? LOAD_VAL : ALU_VAL;
                end
            end
            sh_d = (sh_q != '0) ? sh_q - SH_W'(1) : '0;
            if (issue_c && bus.id_is_branch) begin
                sh_d = SH_VAL;
            end
        end
    end

    // Counter and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            sh_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sh_q <= sh_d;
        end
    end

endmodule
